// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one RAM port between icache and dcache traffic, d priority, error/timeout flag (optional fairness via ARB_FAIR_EN); ports: CLK/nRST, i-side iREN/iaddr/iload/iwait, d-side dREN/dWEN/daddr/dstore/dload/dwait, RAM ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate, arb_err
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic set_err, req, pick_i;
  wire dreq = dREN | dWEN;
  wire acc = ramstate == 2'd2;
  wire rerr = ramstate == 2'd3;
  wire igr = state == IGRANT;
  wire dgr = state == DGRANT;
  wire tout = cnt == CW'(TIMEOUT - 1);
  wire idone = igr & iREN & acc;
  wire ddone = dgr & dreq & acc;
`ifdef ARB_FAIR_EN
  localparam int FW = $clog2(STARVE_LIMIT + 1);
  logic [FW-1:0] fcnt;
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) fcnt <= '0;
    else if (idone || (state == IDLE && !iREN)) fcnt <= '0;
    else if (ddone && iREN && fcnt != FW'(STARVE_LIMIT)) fcnt <= fcnt + 1'b1;
  assign pick_i = iREN & (~dreq | (fcnt == FW'(STARVE_LIMIT)));
`else
  localparam int unused_starve = STARVE_LIMIT;
  assign pick_i = iREN & ~dreq;
`endif
  always_comb begin
    state_n = state;
    set_err = 1'b0;
    req = igr ? iREN : dreq;
    if (state == IDLE) state_n = pick_i ? IGRANT : dreq ? DGRANT : IDLE;
    else begin
      if (!req || acc || rerr || tout) state_n = IDLE;
      set_err = rerr | (tout & ~acc & req) | (dgr & dREN & dWEN);
    end
    // counter only runs while a grant is held; leaving a grant clears it
    cnt_n = (state != IDLE && state_n == state) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge CLK or posedge nRST)
    if (nRST) begin
      state <= IDLE;
      cnt <= '0;
      arb_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      arb_err <= arb_err | set_err;
    end
  assign ramREN = igr ? iREN : dgr ? dREN & ~dWEN : 1'b0;
  assign ramWEN = dgr & dWEN;
  assign ramaddr = igr ? iaddr : dgr ? daddr : '0;
  assign ramstore = dgr ? dstore : '0;
  assign iload = igr ? ramload : '0;
  assign dload = dgr ? ramload : '0;
  assign iwait = ~idone;
  assign dwait = ~ddone;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: scoreboard bench for cache_mem_arbiter with TIMEOUT=8
module tb_cache_mem_arbiter;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  logic CLK = 1'b0, nRST = 1'b1;
  logic iREN = 0, dREN = 0, dWEN = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic [1:0] ramstate = FREE;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic iwait, dwait, ramREN, ramWEN, arb_err;
  typedef struct packed {logic is_d; logic [31:0] data;} exp_t;
  exp_t sbq[$];
  exp_t e;
  int checks = 0, failures = 0;
  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err));
  always #5 CLK = ~CLK;

  task automatic test_reset;
    nRST = 1; iREN = 1; dREN = 1; iaddr = 32'h11; daddr = 32'h22; ramload = 32'hFFFF_FFFF; ramstate = ACC;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait, arb_err} !== 5'b00110) begin failures++; $display("FAIL reset_ctl got=%b exp=00110", {ramREN, ramWEN, iwait, dwait, arb_err}); end
    checks++;
    if (ramaddr !== 0 || ramstore !== 0) begin failures++; $display("FAIL reset_ram got=%h/%h exp=0/0", ramaddr, ramstore); end
    checks++;
    if (iload !== 0 || dload !== 0) begin failures++; $display("FAIL reset_load got=%h/%h exp=0/0", iload, dload); end
    iREN = 0; dREN = 0; ramstate = FREE;
    @(negedge CLK) nRST = 0;
  endtask

  task automatic test_iread;
    @(negedge CLK);
    iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    sbq.push_back('{1'b0, 32'hDEADBEEF});
    #1;
    checks++;
    if (ramREN !== 0 || iwait !== 1) begin failures++; $display("FAIL iread_idle got ren=%b iwait=%b exp 0/1", ramREN, iwait); end
    @(negedge CLK); #1;
    checks++;
    if (ramREN !== 1 || ramaddr !== 32'h40 || iwait !== 1) begin failures++; $display("FAIL iread_grant got ren=%b addr=%h iwait=%b exp 1/40/1", ramREN, ramaddr, iwait); end
    @(negedge CLK); #1;
    checks++;
    if (iwait !== 1) begin failures++; $display("FAIL iread_busy2 got iwait=%b exp 1", iwait); end
    @(negedge CLK);
    ramstate = ACC; ramload = 32'hDEADBEEF;
    #1;
    checks++;
    if (iwait !== 0 || sbq.size() == 0) begin failures++; $display("FAIL iread_done got iwait=%b q=%0d exp 0", iwait, sbq.size()); end
    else begin
      e = sbq.pop_front();
      if (e.is_d !== 0 || iload !== e.data) begin failures++; $display("FAIL iread_data got=%h exp=%h", iload, e.data); end
    end
    @(negedge CLK);
    iREN = 0; ramstate = FREE;
    #1;
    checks++;
    if (iwait !== 1 || ramREN !== 0) begin failures++; $display("FAIL iread_after got iwait=%b ren=%b exp 1/0", iwait, ramREN); end
  endtask

  task automatic test_priority;
    @(negedge CLK);
    iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = BUSY;
    sbq.push_back('{1'b1, 32'h5555});
    sbq.push_back('{1'b0, 32'hCAFE0001});
    #1;
    checks++;
    if ({iwait, dwait, ramWEN} !== 3'b110) begin failures++; $display("FAIL prio_idle got=%b exp=110", {iwait, dwait, ramWEN}); end
    @(negedge CLK); #1;
    checks++;
    if ({ramWEN, ramREN, iwait} !== 3'b101 || ramstore !== 32'h1234 || ramaddr !== 32'h80) begin failures++; $display("FAIL prio_dgrant got=%b st=%h a=%h exp 101/1234/80", {ramWEN, ramREN, iwait}, ramstore, ramaddr); end
    @(negedge CLK);
    ramstate = ACC; ramload = 32'h5555;
    #1;
    checks++;
    if (dwait !== 0 || iwait !== 1 || sbq.size() == 0) begin failures++; $display("FAIL prio_ddone got dwait=%b iwait=%b exp 0/1", dwait, iwait); end
    else begin
      e = sbq.pop_front();
      if (e.is_d !== 1 || dload !== e.data) begin failures++; $display("FAIL prio_ddata got=%h exp=%h", dload, e.data); end
    end
    @(negedge CLK);
    dWEN = 0; ramstate = BUSY;
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin failures++; $display("FAIL prio_turn got=%b exp=0011", {ramREN, ramWEN, iwait, dwait}); end
    @(negedge CLK);
    ramstate = ACC; ramload = 32'hCAFE0001;
    #1;
    checks++;
    if (iwait !== 0 || ramaddr !== 32'h44 || sbq.size() == 0) begin failures++; $display("FAIL prio_idone got iwait=%b a=%h exp 0/44", iwait, ramaddr); end
    else begin
      e = sbq.pop_front();
      if (e.is_d !== 0 || iload !== e.data) begin failures++; $display("FAIL prio_idata got=%h exp=%h", iload, e.data); end
    end
    @(negedge CLK);
    iREN = 0; ramstate = FREE;
    #1;
    checks++;
    if (arb_err !== 0) begin failures++; $display("FAIL prio_noerr got=%b exp=0", arb_err); end
  endtask

  task automatic test_timeout;
    int bad = 0;
    @(negedge CLK);
    dREN = 1; daddr = 32'h10; ramstate = FREE;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK); #1;
      if (dwait !== 1 || ramREN !== 1) bad++;
      if (k == 8) begin
        checks++;
        if (arb_err !== 0) begin failures++; $display("FAIL tout_early got=%b exp=0", arb_err); end
      end
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL tout_grant got bad=%0d exp=0", bad); end
    @(negedge CLK); #1;
    checks++;
    if (arb_err !== 1 || ramREN !== 0 || dwait !== 1) begin failures++; $display("FAIL tout_abort got err=%b ren=%b dwait=%b exp 1/0/1", arb_err, ramREN, dwait); end
    dREN = 0;
    @(negedge CLK); @(negedge CLK); #1;
    checks++;
    if (arb_err !== 1) begin failures++; $display("FAIL tout_sticky got=%b exp=1", arb_err); end
  endtask

  task automatic test_error;
    @(negedge CLK) nRST = 1;
    #1;
    checks++;
    if (arb_err !== 0) begin failures++; $display("FAIL err_clear got=%b exp=0", arb_err); end
    @(negedge CLK);
    nRST = 0; dREN = 1; daddr = 32'h20; ramstate = BUSY;
    sbq.push_back('{1'b1, 32'h77});
    @(negedge CLK);
    ramstate = ERR;
    #1;
    checks++;
    if (dwait !== 1 || ramREN !== 1) begin failures++; $display("FAIL err_wait got dwait=%b ren=%b exp 1/1", dwait, ramREN); end
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    checks++;
    if (arb_err !== 1 || ramREN !== 0) begin failures++; $display("FAIL err_flag got err=%b ren=%b exp 1/0", arb_err, ramREN); end
    @(negedge CLK);
    ramstate = ACC; ramload = 32'h77;
    #1;
    checks++;
    if (dwait !== 0 || ramREN !== 1 || sbq.size() == 0) begin failures++; $display("FAIL err_regrant got dwait=%b ren=%b exp 0/1", dwait, ramREN); end
    else begin
      e = sbq.pop_front();
      if (dload !== e.data) begin failures++; $display("FAIL err_data got=%h exp=%h", dload, e.data); end
    end
    @(negedge CLK);
    dREN = 0; ramstate = FREE;
    @(negedge CLK); #1;
    checks++;
    if (arb_err !== 1) begin failures++; $display("FAIL err_sticky got=%b exp=1", arb_err); end
    @(negedge CLK) nRST = 1;
    #1;
    checks++;
    if (arb_err !== 0) begin failures++; $display("FAIL err_reset got=%b exp=0", arb_err); end
    @(negedge CLK) nRST = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    dREN = 1; dWEN = 1; daddr = 32'h30; dstore = 32'hABCD; ramstate = BUSY;
    @(negedge CLK); #1;
    checks++;
    if (ramWEN !== 1 || ramREN !== 0 || ramstore !== 32'hABCD) begin failures++; $display("FAIL mid_write got wen=%b ren=%b st=%h exp 1/0/abcd", ramWEN, ramREN, ramstore); end
    @(negedge CLK); #1;
    checks++;
    if (arb_err !== 1) begin failures++; $display("FAIL mid_both got err=%b exp=1", arb_err); end
    #2 nRST = 1;
    #1;
    checks++;
    if (ramWEN !== 0 || dwait !== 1 || arb_err !== 0 || ramaddr !== 0) begin failures++; $display("FAIL mid_async got wen=%b dwait=%b err=%b a=%h exp 0/1/0/0", ramWEN, dwait, arb_err, ramaddr); end
    dREN = 0; dWEN = 0; ramstate = FREE;
    @(negedge CLK) nRST = 0;
  endtask

  task automatic test_back_to_back;
    int ic = 0, dc = 0;
    @(negedge CLK);
    dREN = 1; iREN = 1; daddr = 32'h50; iaddr = 32'h60; ramstate = ACC; ramload = 32'h99;
`ifdef ARB_FAIR_EN
    for (int k = 0; k < 6; k++) sbq.push_back('{(k != 4), 32'h99});
`else
    for (int k = 0; k < 6; k++) sbq.push_back('{1'b1, 32'h99});
`endif
    for (int c = 0; c < 12; c++) begin
      #1;
      if (!dwait || !iwait) begin
        ic += !iwait; dc += !dwait;
        checks++;
        if (sbq.size() == 0) begin failures++; $display("FAIL b2b_extra cyc=%0d got i=%b d=%b exp none", c, !iwait, !dwait); end
        else begin
          e = sbq.pop_front();
          if (e.is_d !== !dwait || e.is_d !== iwait || e.data !== (e.is_d ? dload : iload)) begin failures++; $display("FAIL b2b_order cyc=%0d got d=%b i=%b exp d=%b", c, !dwait, !iwait, e.is_d); end
        end
      end
      @(negedge CLK);
    end
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL b2b_missing got left=%0d exp=0", sbq.size()); end
    checks++;
`ifdef ARB_FAIR_EN
    if (ic != 1 || dc != 5) begin failures++; $display("FAIL b2b_count got i=%0d d=%0d exp 1/5", ic, dc); end
`else
    if (ic != 0 || dc != 6) begin failures++; $display("FAIL b2b_count got i=%0d d=%0d exp 0/6", ic, dc); end
`endif
    dREN = 0; iREN = 0; ramstate = FREE;
    sbq.delete();
  endtask

  initial begin
    test_reset;
    test_iread;
    test_priority;
    test_timeout;
    test_error;
    test_reset_mid;
    test_back_to_back;
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
